// File: rtl/tree_pkg.sv
// Shared types and helpers for the tree node hierarchy.
package tree_pkg;

  // Node grant state: free to arbitrate, or holding a packet grant.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } node_state_e;

  // Largest fan-out a single node supports.
  localparam int MAX_CHILDREN = 16;

  // Round-robin pointer increment, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches from ptr upward with wrap;
// when mask_en is set only mask_id may win (packet lock).
module rr_arbiter
  import tree_pkg::*;
#(
  parameter  int N    = 5,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            mask_en,
  input  logic [ID_W-1:0] mask_id,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  int unsigned idx;

  // Pick the locked child, else the first requester at or after ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    if (mask_en) begin
      gnt_valid = req[mask_id];
      gnt_id    = mask_id;
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = 32'(ptr) + 32'(i);
        if (idx >= 32'(N)) idx = idx - 32'(N);
        if (!gnt_valid && req[idx[ID_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_id    = idx[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/tree_node_mux.sv
// Hierarchy node: round-robin merges NUM_CHILDREN valid/ready streams onto
// one registered upstream port, tagging each beat with its source index.
// With PKT_LOCK the grant is held from the first beat of a packet to last.
module tree_node_mux
  import tree_pkg::*;
#(
  parameter  int NUM_CHILDREN = 5,
  parameter  int DATA_W       = 32,
  parameter  int PKT_LOCK     = 1,
  localparam int ID_W         = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN-1:0]        child_last,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           up_valid,
  output logic [DATA_W-1:0]              up_data,
  output logic                           up_last,
  output logic [ID_W-1:0]                up_id,
  input  logic                           up_ready,
  output logic                           locked
);

  if (NUM_CHILDREN < 1 || NUM_CHILDREN > MAX_CHILDREN) begin : g_bad_fanout
    $error("tree_node_mux: NUM_CHILDREN out of range");
  end

  node_state_e       state_q, state_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              up_valid_q, up_valid_d;
  logic [DATA_W-1:0] up_data_q, up_data_d;
  logic              up_last_q, up_last_d;
  logic [ID_W-1:0]   up_id_q, up_id_d;

  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_last;
  logic [DATA_W-1:0] gnt_data;
  logic              load_en;
  logic              accept;

  rr_arbiter #(.N(NUM_CHILDREN)) u_arb (
    .req       (child_valid),
    .ptr       (rr_ptr_q),
    .mask_en   (state_q == LOCKED),
    .mask_id   (lock_id_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Register can take a beat when empty or draining this cycle. Handshakes
  // are suppressed while reset is held so no child believes it was accepted.
  assign load_en  = !up_valid_q || up_ready;
  assign accept   = rst_n && load_en && gnt_valid;
  assign gnt_last = child_last[gnt_id];
  assign gnt_data = child_data[32'(gnt_id) * DATA_W +: DATA_W];

  // One-hot accept toward the granted child.
  always_comb begin
    child_ready = '0;
    if (accept) child_ready[gnt_id] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // FSM next state: lock on a non-last first beat, release on the last beat.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (PKT_LOCK != 0 && accept && !gnt_last) begin
          state_d   = LOCKED;
          lock_id_d = gnt_id;
        end
      end
      LOCKED: begin
        if (accept && gnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Advance the pointer past the winner at packet end (every beat when unlocked).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (gnt_last || PKT_LOCK == 0))
      rr_ptr_d = ID_W'(rr_next(32'(gnt_id), 32'(NUM_CHILDREN)));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Output register next value: load the granted beat, or drain when idle.
  always_comb begin
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_last_d  = up_last_q;
    up_id_d    = up_id_q;
    if (load_en) begin
      up_valid_d = gnt_valid;
      if (gnt_valid) begin
        up_data_d = gnt_data;
        up_last_d = gnt_last;
        up_id_d   = gnt_id;
      end
    end
  end

  // Output register; reset discards any partial packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_last_q  <= 1'b0;
      up_id_q    <= '0;
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_last_q  <= up_last_d;
      up_id_q    <= up_id_d;
    end
  end

  assign up_valid = up_valid_q;
  assign up_data  = up_data_q;
  assign up_last  = up_last_q;
  assign up_id    = up_id_q;

endmodule

// File: tb/tb_tree_node_mux.sv
// Bench for tree_node_mux: reset/table checks, directed multi-cycle sequences,
// and randomized traffic against a packet-level reference model.
module tb_tree_node_mux;

  localparam int N  = 5;
  localparam int DW = 32;

  logic clk, rst_n;

  // index 0: PKT_LOCK=1, index 1: PKT_LOCK=0
  logic [N-1:0]    cv [2];
  logic [N-1:0]    cl [2];
  logic [N*DW-1:0] cd [2];
  logic [N-1:0]    cr [2];
  logic            ur [2];
  logic            uv [2];
  logic [DW-1:0]   udata [2];
  logic            ulast [2];
  logic [2:0]      uid [2];
  logic            lk [2];

  // single-child instance
  logic            c1v, c1l, c1r, u1v, u1l, u1r, u1lk;
  logic [DW-1:0]   c1d, u1d;
  logic [0:0]      u1id;

  int n_chk = 0;
  int n_err = 0;

  tree_node_mux #(.NUM_CHILDREN(N), .DATA_W(DW), .PKT_LOCK(1)) u_lock (
    .clk(clk), .rst_n(rst_n), .child_valid(cv[0]), .child_last(cl[0]), .child_data(cd[0]),
    .child_ready(cr[0]), .up_valid(uv[0]), .up_data(udata[0]), .up_last(ulast[0]),
    .up_id(uid[0]), .up_ready(ur[0]), .locked(lk[0]));

  tree_node_mux #(.NUM_CHILDREN(N), .DATA_W(DW), .PKT_LOCK(0)) u_nolock (
    .clk(clk), .rst_n(rst_n), .child_valid(cv[1]), .child_last(cl[1]), .child_data(cd[1]),
    .child_ready(cr[1]), .up_valid(uv[1]), .up_data(udata[1]), .up_last(ulast[1]),
    .up_id(uid[1]), .up_ready(ur[1]), .locked(lk[1]));

  tree_node_mux #(.NUM_CHILDREN(1), .DATA_W(DW), .PKT_LOCK(1)) u_one (
    .clk(clk), .rst_n(rst_n), .child_valid(c1v), .child_last(c1l), .child_data(c1d),
    .child_ready(c1r), .up_valid(u1v), .up_data(u1d), .up_last(u1l),
    .up_id(u1id), .up_ready(u1r), .locked(u1lk));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- per-child beat queues for directed packet sequences
  logic [DW:0] sq [2][N][$];   // {last, data}

  task automatic src_drive(input int k);
    for (int c = 0; c < N; c++) begin
      if (sq[k][c].size() != 0) begin
        cv[k][c] = 1'b1;
        {cl[k][c], cd[k][c*DW +: DW]} = sq[k][c][0];
      end else begin
        cv[k][c] = 1'b0;
        cl[k][c] = 1'b0;
      end
    end
  endtask

  task automatic src_pop(input int k, input logic [N-1:0] rdy);
    for (int c = 0; c < N; c++)
      if (rdy[c] && sq[k][c].size() != 0) void'(sq[k][c].pop_front());
  endtask

  // ---------------- reference model (packet-level view of the node)
  bit          m_vld [2];
  bit          m_last [2];
  logic [DW-1:0] m_data [2];
  int          m_id [2];
  bit          m_locked [2];
  int          m_lock_id [2];
  int          m_ptr [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_last[k] = 0; m_data[k] = '0; m_id[k] = 0;
      m_locked[k] = 0; m_lock_id[k] = 0; m_ptr[k] = 0;
    end
  endtask

  // Decide who wins this cycle from the rules: the locked owner only, or the
  // first valid child counting up from the pointer modulo N.
  task automatic model_pick(input int k, output bit load, output bit have, output int g);
    load = !m_vld[k] || ur[k];
    have = 0;
    g    = 0;
    if (m_locked[k]) begin
      if (cv[k][m_lock_id[k]]) begin have = 1; g = m_lock_id[k]; end
    end else begin
      for (int j = 0; j < N; j++) begin
        int c;
        c = (m_ptr[k] + j) % N;
        if (!have && cv[k][c]) begin have = 1; g = c; end
      end
    end
  endtask

  task automatic model_commit(input int k, input bit load, input bit have, input int g);
    bit lst;
    if (!load) return;
    if (!have) begin m_vld[k] = 0; return; end
    lst       = cl[k][g];
    m_vld[k]  = 1;
    m_data[k] = cd[k][g*DW +: DW];
    m_last[k] = lst;
    m_id[k]   = g;
    if (k == 0) begin
      if (lst) begin m_locked[k] = 0; m_ptr[k] = (g + 1) % N; end
      else if (!m_locked[k]) begin m_locked[k] = 1; m_lock_id[k] = g; end
    end else begin
      m_ptr[k] = (g + 1) % N;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      cv[k] = '0; cl[k] = '0; cd[k] = '0; ur[k] = 1'b0;
      for (int c = 0; c < N; c++) sq[k][c].delete();
    end
    c1v = 0; c1l = 0; c1d = '0; u1r = 0;
  endtask

  // Ends at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed packet lock sequence on instance k
  task automatic pkt_test(input int k);
    int          exp_id [5];
    bit          exp_lk [5];
    logic [31:0] exp_d [5];
    int          n;
    logic [N-1:0] rdy;
    if (k == 0) begin
      exp_id = '{1, 1, 1, 3, 3};
      exp_lk = '{1, 1, 0, 0, 0};
      exp_d  = '{32'h101, 32'h102, 32'h103, 32'h301, 32'h302};
    end else begin
      exp_id = '{1, 3, 1, 3, 1};
      exp_lk = '{0, 0, 0, 0, 0};
      exp_d  = '{32'h101, 32'h301, 32'h102, 32'h302, 32'h103};
    end
    do_reset();
    sq[k][1].push_back({1'b0, 32'h101});
    sq[k][1].push_back({1'b0, 32'h102});
    sq[k][1].push_back({1'b1, 32'h103});
    sq[k][3].push_back({1'b1, 32'h301});
    sq[k][3].push_back({1'b1, 32'h302});
    ur[k] = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 15 && n < 5; cyc++) begin
      src_drive(k);
      #2 rdy = cr[k];
      @(posedge clk); #1;
      src_pop(k, rdy);
      if (uv[k]) begin
        chk($sformatf("pkt%0d_id[%0d]", k, n), 64'(uid[k]), 64'(exp_id[n]));
        chk($sformatf("pkt%0d_data[%0d]", k, n), 64'(udata[k]), 64'(exp_d[n]));
        chk($sformatf("pkt%0d_locked[%0d]", k, n), 64'(lk[k]), 64'(exp_lk[n]));
        n++;
      end
    end
    chk($sformatf("pkt%0d_beats_done", k), 64'(n), 64'd5);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         up_rdy;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [N-1:0] rdy;

    // grant from an empty register after reset: pointer at 0
    vecs[0] = '{valid: 5'b00000, up_rdy: 1'b1, exp_ready: 5'b00000};
    vecs[1] = '{valid: 5'b00001, up_rdy: 1'b1, exp_ready: 5'b00001};
    vecs[2] = '{valid: 5'b00110, up_rdy: 1'b0, exp_ready: 5'b00010};
    vecs[3] = '{valid: 5'b10000, up_rdy: 1'b1, exp_ready: 5'b10000};
    vecs[4] = '{valid: 5'b11111, up_rdy: 1'b0, exp_ready: 5'b00001};
    vecs[5] = '{valid: 5'b11000, up_rdy: 1'b1, exp_ready: 5'b01000};

    // reset state
    rst_n = 1'b0;
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_up_valid", k), 64'(uv[k]), 64'd0);
      chk($sformatf("rst%0d_up_data", k), 64'(udata[k]), 64'd0);
      chk($sformatf("rst%0d_up_id", k), 64'(uid[k]), 64'd0);
      chk($sformatf("rst%0d_locked", k), 64'(lk[k]), 64'd0);
    end
    chk("rst_one_up_valid", 64'(u1v), 64'd0);
    do_reset();

    // table: combinational grant after reset
    for (int i = 0; i < 6; i++) begin
      cv[0] = vecs[i].valid;
      ur[0] = vecs[i].up_rdy;
      #1 chk($sformatf("table[%0d]_child_ready", i), 64'(cr[0]), 64'(vecs[i].exp_ready));
    end

    // single beat from child 2
    do_reset();
    cv[0] = 5'b00100; cl[0] = 5'b00100; cd[0][2*DW +: DW] = 32'hA5; ur[0] = 1'b1;
    #2 chk("single_child_ready", 64'(cr[0]), 64'b00100);
    @(posedge clk); #1;
    chk("single_up_valid", 64'(uv[0]), 64'd1);
    chk("single_up_data", 64'(udata[0]), 64'hA5);
    chk("single_up_id", 64'(uid[0]), 64'd2);
    chk("single_up_last", 64'(ulast[0]), 64'd1);
    chk("single_rr_ptr", 64'(u_lock.rr_ptr_q), 64'd3);
    cv[0] = 5'b10001; cl[0] = 5'b11111;
    #2 chk("single_next_after_ptr3", 64'(cr[0]), 64'b10000);
    @(posedge clk); #1;
    chk("single_next_id", 64'(uid[0]), 64'd4);
    cv[0] = '0;
    @(posedge clk); #1;
    chk("single_drain", 64'(uv[0]), 64'd0);

    // round robin, no bubbles
    do_reset();
    cv[0] = '1; cl[0] = '1; ur[0] = 1'b1;
    for (int c = 0; c < N; c++) cd[0][c*DW +: DW] = 32'h10 + 32'(c);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr_valid[%0d]", i), 64'(uv[0]), 64'd1);
      chk($sformatf("rr_id[%0d]", i), 64'(uid[0]), 64'(i % N));
      chk($sformatf("rr_data[%0d]", i), 64'(udata[0]), 64'(32'h10 + 32'(i % N)));
    end

    // backpressure
    do_reset();
    cv[0] = 5'b00001; cl[0] = '1; cd[0][0 +: DW] = 32'h11; ur[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_loaded", 64'(udata[0]), 64'h11);
    ur[0] = 1'b0; cv[0] = 5'b00010; cd[0][DW +: DW] = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("bp_child_ready[%0d]", i), 64'(cr[0]), 64'd0);
      chk($sformatf("bp_up_valid[%0d]", i), 64'(uv[0]), 64'd1);
      chk($sformatf("bp_up_data[%0d]", i), 64'(udata[0]), 64'h11);
      chk($sformatf("bp_up_id[%0d]", i), 64'(uid[0]), 64'd0);
      @(posedge clk); #1;
    end
    ur[0] = 1'b1;
    #2 chk("bp_release_ready", 64'(cr[0]), 64'b00010);
    @(posedge clk); #1;
    chk("bp_next_data", 64'(udata[0]), 64'h22);
    chk("bp_next_id", 64'(uid[0]), 64'd1);

    // packet lock / no-lock interleave
    pkt_test(0);
    pkt_test(1);

    // reset mid-packet
    do_reset();
    sq[0][1].push_back({1'b0, 32'h101});
    sq[0][1].push_back({1'b0, 32'h102});
    sq[0][1].push_back({1'b1, 32'h103});
    ur[0] = 1'b1;
    src_drive(0);
    #2 rdy = cr[0];
    @(posedge clk); #1;
    src_pop(0, rdy);
    chk("mid_locked_before", 64'(lk[0]), 64'd1);
    src_drive(0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_up_valid", 64'(uv[0]), 64'd0);
    chk("mid_up_data", 64'(udata[0]), 64'd0);
    chk("mid_up_last", 64'(ulast[0]), 64'd0);
    chk("mid_up_id", 64'(uid[0]), 64'd0);
    chk("mid_locked", 64'(lk[0]), 64'd0);
    chk("mid_child_ready", 64'(cr[0]), 64'd0);
    sq[0][1].delete();
    cv[0] = 5'b01011; cl[0] = '1;
    @(posedge clk); #1 rst_n = 1'b1;
    #2 chk("mid_restart_ready", 64'(cr[0]), 64'b00001);
    @(posedge clk); #1;
    chk("mid_restart_id", 64'(uid[0]), 64'd0);
    chk("mid_restart_locked", 64'(lk[0]), 64'd0);

    // single-child node
    do_reset();
    c1v = 1'b1; c1l = 1'b0; c1d = 32'h5A; u1r = 1'b1;
    #2 chk("one_ready", 64'(c1r), 64'd1);
    @(posedge clk); #1;
    chk("one_up_data", 64'(u1d), 64'h5A);
    chk("one_up_id", 64'(u1id), 64'd0);
    chk("one_locked", 64'(u1lk), 64'd1);
    c1l = 1'b1; c1d = 32'h5B;
    @(posedge clk); #1;
    chk("one_up_data2", 64'(u1d), 64'h5B);
    chk("one_unlocked", 64'(u1lk), 64'd0);
    c1v = 1'b0;

    // randomized traffic vs model
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit ld [2];
      bit hv [2];
      int gg [2];
      for (int k = 0; k < 2; k++) begin
        cv[k] = N'($urandom);
        cl[k] = N'($urandom & $urandom);
        for (int c = 0; c < N; c++) cd[k][c*DW +: DW] = $urandom;
        ur[k] = ($urandom_range(0, 3) != 0);
      end
      #2;
      for (int k = 0; k < 2; k++) begin
        logic [N-1:0] er;
        chk($sformatf("rnd%0d_up_valid@%0d", k, cyc), 64'(uv[k]), 64'(m_vld[k]));
        if (m_vld[k]) begin
          chk($sformatf("rnd%0d_up_data@%0d", k, cyc), 64'(udata[k]), 64'(m_data[k]));
          chk($sformatf("rnd%0d_up_last@%0d", k, cyc), 64'(ulast[k]), 64'(m_last[k]));
          chk($sformatf("rnd%0d_up_id@%0d", k, cyc), 64'(uid[k]), 64'(m_id[k]));
        end
        chk($sformatf("rnd%0d_locked@%0d", k, cyc), 64'(lk[k]), 64'(m_locked[k]));
        model_pick(k, ld[k], hv[k], gg[k]);
        er = (ld[k] && hv[k]) ? N'(1 << gg[k]) : '0;
        chk($sformatf("rnd%0d_child_ready@%0d", k, cyc), 64'(cr[k]), 64'(er));
        model_commit(k, ld[k], hv[k], gg[k]);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tree_node_mux.md
# tree_node_mux

Parametrised hierarchy node that merges the traffic of `NUM_CHILDREN` child instances onto one upstream port. Children present valid/ready streams. A round-robin arbiter selects one child, optionally holding the grant for a whole packet. The selected beat is tagged with the child index and registered onto the upstream port. The node replaces fixed-fan-out root wrappers and is instantiated recursively, with each level feeding the next.

## Interface
- `NUM_CHILDREN`, default 5: number of child ports, 1..16.
- `DATA_W`, default 32: payload width per beat.
- `PKT_LOCK`, default 1:
  - 1: the grant is held from first beat to `last`.
  - 0: the grant re-arbitrates every beat.
- `ID_W`: derived as max(1, $clog2(NUM_CHILDREN)). Not overridable.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `child_valid`, in, NUM_CHILDREN: per-child beat valid.
- `child_last`, in, NUM_CHILDREN: per-child end-of-packet marker.
- `child_data`, in, NUM_CHILDREN*DATA_W: child i occupies bits [i*DATA_W +: DATA_W].
- `child_ready`, out, NUM_CHILDREN: per-child accept. One-hot or zero.
- `up_valid`, out, 1: upstream beat valid.
- `up_data`, out, DATA_W: upstream payload.
- `up_last`, out, 1: upstream end-of-packet.
- `up_id`, out, ID_W: index of the source child.
- `up_ready`, in, 1: upstream accept.
- `locked`, out, 1: high while a packet grant is held.

## Operation
- **Output register.** Holds one beat: `up_valid`, `up_data`, `up_last`, `up_id`.
  - `load_en` = !up_valid || up_ready.
  - When `load_en` is high, the register loads the granted child's beat, or clears `up_valid` if no child is granted.
- **Arbiter.** Round-robin pointer `rr_ptr` (ID_W bits).
  - When IDLE, the grant goes to the first valid child at index ≥ `rr_ptr`, wrapping modulo NUM_CHILDREN.
  - `child_ready[g]` = load_en && grant valid && (g == granted index). The output is combinational.
- **FSM states.** IDLE and LOCKED.
  - IDLE → LOCKED: a beat is accepted with `last`=0 and `PKT_LOCK`=1. The grant index is latched into `lock_id`.
  - LOCKED: only `lock_id` can be granted. Other children are stalled even if valid.
  - LOCKED → IDLE: a beat is accepted from `lock_id` with `last`=1.
  - `PKT_LOCK`=0: the FSM stays in IDLE permanently and `locked` is always 0.
- **Pointer update.** On a beat accepted with last=1, or on any accepted beat when `PKT_LOCK`=0, `rr_ptr` ← granted+1, wrapping NUM_CHILDREN−1 → 0. There is no update while LOCKED mid-packet.
- **Reset values.**
  - `up_valid`=0, `up_last`=0, `up_data`=0, `up_id`=0.
  - `child_ready`=0, `locked`=0, `rr_ptr`=0, state IDLE.
- **Boundary conditions.**
  - No child valid: `child_ready`=0 and the register drains.
  - LOCKED while `lock_id` has no valid beat: no grant. Other children wait and the lock persists.
  - `NUM_CHILDREN`=1: the arbiter degenerates to pass-through plus register. `up_id`=0.
  - Reset mid-packet: the lock is dropped and a partial packet in the register is discarded. The upstream is responsible for truncated-packet handling.
  - `child_valid` deasserted without a handshake is tolerated. The arbiter re-evaluates every cycle.

## Timing
- Latency: 1 cycle from a child handshake to `up_valid`.
- Throughput: 1 beat/cycle under continuous `up_ready`=1.
- `up_data`, `up_last` and `up_id` are held stable while up_valid && !up_ready.
- `child_ready` depends combinationally on `up_ready` and `child_valid`. There is no comb path from `child_data` to any output.
- The grant changes only at the clock edge following an accepted last beat when `PKT_LOCK`=1.

## Structure
- Shared package `tree_pkg`:
  - `node_state_e` {IDLE, LOCKED}.
  - `MAX_CHILDREN`=16.
  - Function `rr_next(ptr, n)` implementing the wrapped increment.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]`, `ptr`, `mask_en`, `mask_id`.
  - Outputs `gnt_valid`, `gnt_id`.
  - Purely combinational.
- `tree_node_mux` holds the FSM, pointer and output register.

## Test plan
- **Single child.** Child 2 sends one beat, data 0xA5, last=1, with `up_ready`=1. Expect `up_valid` the next cycle, `up_data`=0xA5, `up_id`=2, and `rr_ptr`=3 afterwards.
- **Round robin.** All 5 children hold single-beat packets continuously with `up_ready`=1. Expect `up_id` sequence 0,1,2,3,4,0,1 with no bubbles.
- **Backpressure.** Hold `up_ready`=0 for 4 cycles with a beat loaded. Expect the upstream outputs stable, `child_ready`=0 throughout, and the beat delivered when `up_ready` rises.
- **Packet lock.** Child 1 sends a 3-beat packet while child 3 is valid. Expect `up_id`=1,1,1 and `locked`=1 for the first two accepts, then child 3. With `PKT_LOCK`=0 the same stimulus gives interleaved 1,3,1,3,1.
- **Reset mid-packet.** Assert `rst_n`=0 asynchronously during beat 2 of a packet. Expect all outputs zero immediately and `locked`=0. After release, arbitration restarts from child 0.
